// File: rtl/mips_dmem_io_pkg.sv
// Address map and shared types for the data-memory / memory-mapped IO unit.
package mips_dmem_io_pkg;

    localparam logic [7:0] IO_BASE      = 8'hF0;
    localparam logic [7:0] IO_GPIO_OUT  = 8'hF0;
    localparam logic [7:0] IO_GPIO_IN   = 8'hF1;
    localparam logic [7:0] IO_FIFO_DATA = 8'hF2;
    localparam logic [7:0] IO_FIFO_STAT = 8'hF3;
    localparam logic [7:0] IO_CYCLE_LO  = 8'hF4;
    localparam logic [7:0] IO_CYCLE_HI  = 8'hF5;
    localparam logic [7:0] IO_DROP      = 8'hF6;

    typedef struct packed {
        logic       vld;
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdat;
    } dmem_req_t;

    function automatic logic [7:0] fifo_stat(input logic empty, input logic full,
                                             input logic [2:0] cnt);
        return {3'b000, empty, full, cnt};
    endfunction

endpackage

// File: rtl/mips_dmem_io_byte_fifo.sv
// Byte FIFO with push/pop/flush and occupancy flags; head is shown combinationally.
// Latency: a pushed byte is visible at head the cycle after the push edge.
// Backpressure: a push while full is refused (push_drop) unless a pop frees a slot the same cycle.
module byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [7:0]               push_dat,
    input  logic                     pop,
    input  logic                     flush,
    output logic [7:0]               head,
    output logic [$clog2(DEPTH):0]   cnt,
    output logic                     full,
    output logic                     empty,
    output logic                     push_drop
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_pop;
    logic             do_push;

    assign empty     = (cnt == '0);
    assign full      = (cnt == (PTR_W+1)'(DEPTH));
    assign do_pop    = pop && !empty;
    assign do_push   = push && (!full || do_pop);
    assign push_drop = push && full && !do_pop;
    assign head      = empty ? 8'h00 : mem[rd_ptr];

    // Flush wins over a same-cycle pop; pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/mips_dmem_io.sv
// Data RAM plus memory-mapped GPIO, cycle counter and output byte FIFO behind the MA stage.
// Latency: stores commit at the request edge; load data lands on mem_r one cycle later (WB).
// Backpressure: none toward the core; out_valid/out_ready drains the FIFO, overflow pushes are counted.
module mips_dmem_io
    import mips_dmem_io_pkg::*;
#(
    parameter logic [7:0] RAM_TOP    = 8'hEF,
    parameter int         FIFO_DEPTH = 4,
    parameter int         CNT_W      = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       breq,
    input  logic [7:0] mem_rw_addr,
    input  logic [7:0] mem_w,
    input  logic       mem_w_en,
    output logic [7:0] mem_r,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    input  logic [7:0] gpio_in,
    output logic [7:0] gpio_out
);

    localparam int RAM_WORDS = int'(RAM_TOP) + 1;

    dmem_req_t  req;
    logic       load;
    logic       store;
    logic       is_ram;
    logic [7:0] ram [RAM_WORDS];
    logic [7:0] ram_rd;
    logic [7:0] io_rd;

    logic [CNT_W-1:0] cyc;
    logic [7:0]       cyc_hi;
    logic [7:0]       gpio_smp;
    logic [7:0]       drop_cnt;

    logic                          fifo_push;
    logic                          fifo_flush;
    logic                          fifo_full;
    logic                          fifo_empty;
    logic                          fifo_drop;
    logic [$clog2(FIFO_DEPTH):0]   fifo_cnt;

    assign req    = '{vld: breq, we: mem_w_en, addr: mem_rw_addr, wdat: mem_w};
    assign load   = req.vld && !req.we;
    assign store  = req.vld && req.we;
    assign is_ram = (req.addr <= RAM_TOP);

    assign fifo_push  = store && !is_ram && (req.addr == IO_FIFO_DATA);
    assign fifo_flush = store && !is_ram && (req.addr == IO_FIFO_STAT);

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_dat  (req.wdat),
        .pop       (out_ready),
        .flush     (fifo_flush),
        .head      (out_data),
        .cnt       (fifo_cnt),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .push_drop (fifo_drop)
    );

    assign out_valid = !fifo_empty;

    // RAM is not cleared by reset, but stores presented during reset are discarded.
    always_ff @(posedge clk) begin
        if (rst && store && is_ram) ram[req.addr] <= req.wdat;
    end

    assign ram_rd = ram[req.addr];

    always_comb begin
        io_rd = 8'h00;
        case (req.addr)
            IO_GPIO_OUT:  io_rd = gpio_out;
            IO_GPIO_IN:   io_rd = gpio_smp;
            IO_FIFO_STAT: io_rd = fifo_stat(fifo_empty, fifo_full, 3'(fifo_cnt));
            IO_CYCLE_LO:  io_rd = cyc[7:0];
            IO_CYCLE_HI:  io_rd = cyc_hi;
            IO_DROP:      io_rd = drop_cnt;
            default:      io_rd = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_r    <= 8'h00;
            gpio_out <= 8'h00;
            cyc      <= '0;
            cyc_hi   <= 8'h00;
            gpio_smp <= 8'h00;
            drop_cnt <= 8'h00;
        end else begin
            cyc      <= cyc + 1'b1;
            gpio_smp <= gpio_in;
            if (load) begin
                mem_r <= is_ram ? ram_rd : io_rd;
                // Reading LO freezes HI so software gets a coherent 16-bit pair.
                if (!is_ram && req.addr == IO_CYCLE_LO) cyc_hi <= cyc[CNT_W-1 -: 8];
            end
            if (store && !is_ram && req.addr == IO_GPIO_OUT) gpio_out <= req.wdat;
            if (fifo_flush)
                drop_cnt <= 8'h00;
            else if (fifo_drop && drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 1'b1;
        end
    end

endmodule

// File: doc/mips_dmem_io.md
Name: mips_dmem_io

Overview:
Data-memory and memory-mapped I/O unit sitting directly downstream of the core's MA stage. It consumes the core's byte load/store bus (breq, mem_rw_addr, mem_w, mem_w_en) and returns load data on mem_r one cycle later, aligned with the core's WB stage. Addresses 0x00-0xEF map to on-chip RAM. Addresses 0xF0-0xFF map to peripheral registers: GPIO, a cycle counter, and a 4-entry output byte FIFO drained by a valid/ready port.

Parameters:
RAM_TOP, 8'hEF, highest RAM address; IO region starts at RAM_TOP+1
FIFO_DEPTH, 4, output FIFO entries (power of 2)
CNT_W, 16, cycle counter width (fixed: LO/HI bytes)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-low reset (0 = reset, sampled on clk rising edge)
breq  input  1  memory access request from MA stage
mem_rw_addr  input  8  byte address
mem_w  input  8  store data
mem_w_en  input  1  store strobe; meaningful only with breq
mem_r  output  8  load data, valid the cycle after a load request
out_data  output  8  FIFO head byte
out_valid  output  1  FIFO non-empty
out_ready  input  1  downstream accepts out_data
gpio_in  input  8  external input pins
gpio_out  output  8  GPIO output register

Behaviour:
- Reset (rst=0 at posedge): mem_r=0, gpio_out=0, FIFO empty (out_valid=0, out_data=0), cycle counter=0, HI shadow=0, drop count=0, gpio_in sample=0. RAM contents are not reset.
- Access types: store = breq&&mem_w_en; load = breq&&!mem_w_en. With breq=0, mem_w_en is ignored and no state changes except counter/FIFO pop.
- Store latency: the store commits at the posedge where it is presented. A load of the same address on the next cycle returns the new value.
- Load latency: exactly 1 cycle. mem_r is registered at the posedge of the load and holds until the next load; stores do not alter mem_r.
- RAM: 240x8 single port, addresses 0x00..RAM_TOP.
- IO map, with R/W behaviour:
  - 0xF0 GPIO_OUT: read/write.
  - 0xF1 GPIO_IN: read only. Returns gpio_in registered once per cycle, so it is 1 cycle stale.
  - 0xF2 FIFO_DATA: a write pushes; a read returns 0.
  - 0xF3 FIFO_STAT: read returns {3'b0, empty, full, count[2:0]}. A write of any value flushes the FIFO and clears drop count.
  - 0xF4 CYCLE_LO: read returns counter[7:0] and, in the same cycle, latches counter[15:8] into the HI shadow.
  - 0xF5 CYCLE_HI: read returns the HI shadow, not the live counter.
  - 0xF6 DROP: read returns the count of pushes rejected while full, saturating at 0xFF.
  - 0xF7-0xFF: reads return 0; writes are ignored. Writes to read-only registers are ignored.
- Cycle counter: increments every non-reset cycle and wraps 0xFFFF->0x0000.
- FIFO:
  - Pop occurs when out_valid&&out_ready.
  - Push when full: if a pop happens in the same cycle, the push is accepted and count stays 4. Otherwise the byte is dropped and DROP increments.
  - Push and pop in the same cycle when not full: count unchanged.
  - Flush has priority over a same-cycle pop; count becomes 0.
  - out_data is the head entry, or 0 when empty. out_valid is combinational from count!=0.
  - Pointers wrap modulo FIFO_DEPTH.
- Reset mid-operation: everything is cleared on that edge, any pending load result is lost (mem_r=0), and out_valid=0 after the edge.

Decomposition:
- Shared header holds the address-map constants: IO_GPIO_OUT, IO_GPIO_IN, IO_FIFO_DATA, IO_FIFO_STAT, IO_CYCLE_LO, IO_CYCLE_HI, IO_DROP, IO_BASE.
- The core and software tests include the same header.
- One sub-module, byte_fifo: parameterised depth, push/pop/flush, count/full/empty, head output.
- RAM, register decode, counter and mem_r register stay in mips_dmem_io.

Test Plan:
- Store 0x5A to 0x10, then load 0x10 on the next cycle -> mem_r=0x5A exactly one cycle after the load. Load 0x11 with no prior store, then store 0x77 to 0x20 -> mem_r unchanged by the store.
- Store 0xC3 to 0xF0 -> gpio_out=0xC3 after the edge. Drive gpio_in=0x3C, wait 2 cycles, load 0xF1 -> mem_r=0x3C. Load 0xF9 -> 0x00.
- Hold out_ready=0 and push 0x01..0x06 to 0xF2 -> FIFO_STAT=0x0C (full, count 4), DROP=2, out_data=0x01. Raise out_ready -> out_data sequence 01,02,03,04, then out_valid=0 and FIFO_STAT=0x10.
- FIFO full with out_ready=1 and a push of 0xAA in the same cycle -> push accepted, DROP unchanged, count stays 4. Then write 0xF3 -> count 0, DROP 0, out_valid=0 next cycle.
- Run to counter 0x01FF, load 0xF4 -> 0xFF. Load 0xF5 several cycles later -> 0x01 (shadow, not the live 0x02). Counter wraps from 0xFFFF to 0x0000.
- Assert rst=0 with FIFO count 3, gpio_out=0xC3 and a load in flight -> at the next edge mem_r=0, gpio_out=0, out_valid=0, FIFO_STAT reads 0x10 after release.
